// File: rtl/bit_rate_monitor.sv
`default_nettype none
// ============================================================================
// bit_rate_monitor : moving average of bit-rate samples with hysteretic alarms
// Option macro: BIT_RATE_MONITOR_MINMAX_EN (min/max tracking) | Rev 1.0
// ============================================================================
module bit_rate_monitor #(
   parameter int RES_WIDTH = 32,
   parameter int AVG_LOG2  = 2,
   parameter int HYST_CNT  = 3
) (
   input  logic                 clk_i,
   input  logic                 s_rst_i,
   input  logic [RES_WIDTH-1:0] bit_rate_i,
   input  logic                 bit_rate_valid_i,
   input  logic                 clr_i,
   input  logic [RES_WIDTH-1:0] low_thr_i,
   input  logic [RES_WIDTH-1:0] high_thr_i,
   output logic [RES_WIDTH-1:0] avg_rate_o,
   output logic                 avg_valid_o,
   output logic [RES_WIDTH-1:0] min_rate_o,
   output logic [RES_WIDTH-1:0] max_rate_o,
   output logic [1:0]           state_o,
   output logic                 alarm_o
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = RES_WIDTH + AVG_LOG2;

   localparam logic [1:0] ST_FILL   = 2'd0;
   localparam logic [1:0] ST_NORMAL = 2'd1;
   localparam logic [1:0] ST_LOW    = 2'd2;
   localparam logic [1:0] ST_HIGH   = 2'd3;

   localparam logic [3:0]          HYST_LIM  = 4'(HYST_CNT);
   localparam logic [AVG_LOG2:0]   FILL_LAST = (AVG_LOG2+1)'(DEPTH-1);
   localparam logic [AVG_LOG2:0]   FILL_ONE  = (AVG_LOG2+1)'(1);
   localparam logic [AVG_LOG2-1:0] PTR_ONE   = AVG_LOG2'(1);

   logic [RES_WIDTH-1:0] win_q [DEPTH];
   logic [AVG_LOG2-1:0]  wr_ptr_q;
   logic [AVG_LOG2:0]    fill_q;
   logic [SUM_W-1:0]     sum_q, sum_d;
   logic [RES_WIDTH-1:0] avg_rate_q;
   logic                 avg_valid_q;
   logic [1:0]           state_q, state_d;
   logic [3:0]           hyst_q, hyst_d;
   logic                 dir_q, dir_d;
   logic                 alarm_q;

   logic                 w_accept;
   logic                 w_full;
   logic                 w_will_full;
   logic [RES_WIDTH-1:0] w_old;
   logic                 w_lo;
   logic                 w_hi;
   logic                 w_dir_new;
   logic [3:0]           w_cnt_inc;
   logic [3:0]           w_ret_inc;

   // Clear wins over a coincident sample.
   assign w_accept    = bit_rate_valid_i & ~clr_i;
   // Fill count saturates at DEPTH, whose only set bit is the MSB.
   assign w_full      = fill_q[AVG_LOG2];
   assign w_will_full = w_full | (fill_q == FILL_LAST);
   assign w_old       = w_full ? win_q[wr_ptr_q] : '0;
   assign sum_d       = sum_q + SUM_W'(bit_rate_i) - SUM_W'(w_old);

   assign w_lo      = avg_rate_q < low_thr_i;
   assign w_hi      = avg_rate_q > high_thr_i;
   assign w_dir_new = ~w_lo;
   assign w_cnt_inc = ((hyst_q != 4'd0) && (dir_q != w_dir_new)) ? 4'd1 : hyst_q + 4'd1;
   assign w_ret_inc = hyst_q + 4'd1;

   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         win_q[wr_ptr_q] <= bit_rate_i;
      end
   end

   always_comb begin
      state_d = state_q;
      hyst_d  = hyst_q;
      dir_d   = dir_q;
      if (avg_valid_q) begin
         case (state_q)
            ST_FILL, ST_NORMAL: begin
               if (w_lo || w_hi) begin
                  dir_d = w_dir_new;
                  if (state_q == ST_FILL) begin
                     state_d = ST_NORMAL;
                     hyst_d  = w_cnt_inc;
                  end else if (w_cnt_inc >= HYST_LIM) begin
                     state_d = w_dir_new ? ST_HIGH : ST_LOW;
                     hyst_d  = 4'd0;
                  end else begin
                     hyst_d = w_cnt_inc;
                  end
               end else begin
                  state_d = ST_NORMAL;
                  hyst_d  = 4'd0;
               end
            end
            default: begin
               if ((state_q == ST_LOW) ? !w_lo : !w_hi) begin
                  if (w_ret_inc >= HYST_LIM) begin
                     state_d = ST_NORMAL;
                     hyst_d  = 4'd0;
                  end else begin
                     hyst_d = w_ret_inc;
                  end
               end else begin
                  hyst_d = 4'd0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (s_rst_i || clr_i) begin
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         sum_q       <= '0;
         avg_rate_q  <= '0;
         avg_valid_q <= 1'b0;
         state_q     <= ST_FILL;
         hyst_q      <= 4'd0;
         dir_q       <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         avg_valid_q <= 1'b0;
         if (w_accept) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
            sum_q    <= sum_d;
            if (!w_full) begin
               fill_q <= fill_q + FILL_ONE;
            end
            if (w_will_full) begin
               avg_valid_q <= 1'b1;
               avg_rate_q  <= sum_d[SUM_W-1:AVG_LOG2];
            end
         end
         state_q <= state_d;
         hyst_q  <= hyst_d;
         dir_q   <= dir_d;
         alarm_q <= state_d[1];
      end
   end

`ifdef BIT_RATE_MONITOR_MINMAX_EN
   logic [RES_WIDTH-1:0] min_q, max_q;

   always_ff @(posedge clk_i) begin
      if (s_rst_i || clr_i) begin
         min_q <= '1;
         max_q <= '0;
      end else if (w_accept) begin
         if (bit_rate_i < min_q) min_q <= bit_rate_i;
         if (bit_rate_i > max_q) max_q <= bit_rate_i;
      end
   end

   assign min_rate_o = min_q;
   assign max_rate_o = max_q;
`else
   assign min_rate_o = '0;
   assign max_rate_o = '0;
`endif

   assign avg_rate_o  = avg_rate_q;
   assign avg_valid_o = avg_valid_q;
   assign state_o     = state_q;
   assign alarm_o     = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_rate_monitor.sv
`default_nettype none
// Scoreboard bench for bit_rate_monitor: expected averages are queued by the
// stimulus and popped by a monitor on every avg_valid_o pulse.
module tb_bit_rate_monitor;

   localparam int W = 32;
`ifdef BIT_RATE_MONITOR_MINMAX_EN
   localparam bit MM = 1'b1;
`else
   localparam bit MM = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          s_rst_i;
   logic [W-1:0]  bit_rate_i;
   logic          bit_rate_valid_i;
   logic          clr_i;
   logic [W-1:0]  low_thr_i;
   logic [W-1:0]  high_thr_i;
   logic [W-1:0]  avg_rate_o;
   logic          avg_valid_o;
   logic [W-1:0]  min_rate_o;
   logic [W-1:0]  max_rate_o;
   logic [1:0]    state_o;
   logic          alarm_o;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [W-1:0]  exp_q [$];

   always #5 clk_i = ~clk_i;

   bit_rate_monitor #(.RES_WIDTH(W), .AVG_LOG2(2), .HYST_CNT(3)) dut (
      .clk_i            (clk_i),
      .s_rst_i          (s_rst_i),
      .bit_rate_i       (bit_rate_i),
      .bit_rate_valid_i (bit_rate_valid_i),
      .clr_i            (clr_i),
      .low_thr_i        (low_thr_i),
      .high_thr_i       (high_thr_i),
      .avg_rate_o       (avg_rate_o),
      .avg_valid_o      (avg_valid_o),
      .min_rate_o       (min_rate_o),
      .max_rate_o       (max_rate_o),
      .state_o          (state_o),
      .alarm_o          (alarm_o)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every averaging pulse must match the oldest queued expectation.
   always @(negedge clk_i) begin
      if (avg_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_avg: got 0x%0h expected no pulse", avg_rate_o);
         end else begin
            chk("avg_rate", avg_rate_o, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [W-1:0] v, input bit has_avg, input logic [W-1:0] e);
      if (has_avg) exp_q.push_back(e);
      bit_rate_i       = v;
      bit_rate_valid_i = 1'b1;
      @(negedge clk_i);
      bit_rate_valid_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic chk_state(input string name, input logic [1:0] st, input logic al);
      chk({name, "_state"}, W'(state_o), W'(st));
      chk({name, "_alarm"}, W'(alarm_o), W'(al));
   endtask

   task automatic pulse_clr();
      clr_i = 1'b1;
      @(negedge clk_i);
      clr_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      s_rst_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      s_rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   initial begin
      s_rst_i          = 1'b0;
      clr_i            = 1'b0;
      bit_rate_i       = '0;
      bit_rate_valid_i = 1'b0;
      low_thr_i        = 32'd100;
      high_thr_i       = 32'd1000;
      @(negedge clk_i);
      do_reset();

      chk("rst_avg", avg_rate_o, 32'd0);
      chk("rst_valid", W'(avg_valid_o), 32'd0);
      chk("rst_min", min_rate_o, MM ? 32'hFFFF_FFFF : 32'd0);
      chk("rst_max", max_rate_o, 32'd0);
      chk_state("rst", 2'd0, 1'b0);

      // Fill: first average only after the fourth sample.
      send(32'd100, 1'b0, '0);
      send(32'd200, 1'b0, '0);
      send(32'd300, 1'b0, '0);
      chk("fill_avg_hold", avg_rate_o, 32'd0);
      chk_state("fill", 2'd0, 1'b0);
      send(32'd400, 1'b1, 32'd250);
      chk_state("first_avg", 2'd1, 1'b0);
      chk("mm_min1", min_rate_o, MM ? 32'd100 : 32'd0);
      chk("mm_max1", max_rate_o, MM ? 32'd400 : 32'd0);

      // Low entry after three consecutive averages of 50.
      pulse_clr();
      chk_state("clr1", 2'd0, 1'b0);
      for (int i = 0; i < 3; i++) send(32'd50, 1'b0, '0);
      send(32'd50, 1'b1, 32'd50);
      send(32'd50, 1'b1, 32'd50);
      chk_state("low_pending", 2'd1, 1'b0);
      send(32'd50, 1'b1, 32'd50);
      chk_state("low_entry", 2'd2, 1'b1);

      // Low exit: averages below 100 clear, three of exactly 100 return.
      send(32'd100, 1'b1, 32'd62);
      send(32'd100, 1'b1, 32'd75);
      send(32'd100, 1'b1, 32'd87);
      chk_state("low_hold", 2'd2, 1'b1);
      send(32'd100, 1'b1, 32'd100);
      send(32'd100, 1'b1, 32'd100);
      chk_state("low_hold2", 2'd2, 1'b1);
      send(32'd100, 1'b1, 32'd100);
      chk_state("low_exit", 2'd1, 1'b0);

      // High entry with an intervening average of exactly 1000.
      send(32'd1000, 1'b1, 32'd325);
      send(32'd1000, 1'b1, 32'd550);
      send(32'd1000, 1'b1, 32'd775);
      send(32'd1000, 1'b1, 32'd1000);
      send(32'd1400, 1'b1, 32'd1100);
      send(32'd600,  1'b1, 32'd1000);
      send(32'd2000, 1'b1, 32'd1250);
      send(32'd2000, 1'b1, 32'd1500);
      chk_state("high_pending", 2'd1, 1'b0);
      send(32'd2000, 1'b1, 32'd1650);
      chk_state("high_entry", 2'd3, 1'b1);
      chk("mm_min2", min_rate_o, MM ? 32'd50 : 32'd0);
      chk("mm_max2", max_rate_o, MM ? 32'd2000 : 32'd0);

      // Clear together with a sample: the sample is dropped.
      bit_rate_i       = 32'd999;
      bit_rate_valid_i = 1'b1;
      clr_i            = 1'b1;
      @(negedge clk_i);
      bit_rate_valid_i = 1'b0;
      clr_i            = 1'b0;
      @(negedge clk_i);
      chk_state("clr2", 2'd0, 1'b0);
      chk("clr2_avg", avg_rate_o, 32'd0);
      chk("clr2_min", min_rate_o, MM ? 32'hFFFF_FFFF : 32'd0);
      chk("clr2_max", max_rate_o, 32'd0);
      send(32'd10, 1'b0, '0);
      send(32'd20, 1'b0, '0);
      send(32'd30, 1'b0, '0);
      send(32'd40, 1'b1, 32'd25);

      // Reset mid-fill, then full-scale sum stress and pointer wrap.
      pulse_clr();
      send(32'd7, 1'b0, '0);
      send(32'd7, 1'b0, '0);
      do_reset();
      chk_state("rst2", 2'd0, 1'b0);
      for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF, 1'b0, '0);
      send(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
      chk_state("stress", 2'd1, 1'b0);
      send(32'd0, 1'b1, 32'hBFFF_FFFF);

      repeat (3) @(negedge clk_i);
      chk("queue_empty", W'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
